// File: rtl/clint_ahb_timer_if.sv
// ----------------------------------------------------------------------------
// clint_ahb_timer_if
//
// AHB-Lite slave-side bundle for the CLINT timer block.
//
// Handshake: an address phase is taken when HSELCLINT, HREADY and HTRANS[1]
// are all 1 at a rising HCLK edge. The matching data phase is the following
// cycle. During it, HWDATA carries write data and HREADCLINT carries read data.
// The slave never stalls (HREADYCLINT=1) and never errors (HRESPCLINT=0).
//
// Signals:
//   HSELCLINT    master->slave  slave select
//   HADDR[15:0]  master->slave  byte offset within the CLINT region
//   HWRITE       master->slave  1 = write transfer
//   HTRANS[1:0]  master->slave  transfer type, bit 1 = NONSEQ/SEQ
//   HSIZE[2:0]   master->slave  transfer size, 0=byte .. 3=dword
//   HREADY       master->slave  bus-wide ready
//   HWDATA       master->slave  write data (data phase)
//   HREADCLINT   slave->master  read data (data phase)
//   HREADYCLINT  slave->master  always 1
//   HRESPCLINT   slave->master  always 0
// ----------------------------------------------------------------------------
interface clint_ahb_timer_if #(
    parameter int XLEN = 64
);
    logic            HSELCLINT;
    logic [15:0]     HADDR;
    logic            HWRITE;
    logic [1:0]      HTRANS;
    logic [2:0]      HSIZE;
    logic            HREADY;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HREADCLINT;
    logic            HREADYCLINT;
    logic            HRESPCLINT;

    modport master (
        output HSELCLINT, HADDR, HWRITE, HTRANS, HSIZE, HREADY, HWDATA,
        input  HREADCLINT, HREADYCLINT, HRESPCLINT
    );

    modport slave (
        input  HSELCLINT, HADDR, HWRITE, HTRANS, HSIZE, HREADY, HWDATA,
        output HREADCLINT, HREADYCLINT, HRESPCLINT
    );
endinterface

// File: rtl/clint_ahb_timer.sv
// ----------------------------------------------------------------------------
// clint_ahb_timer
//
// Core-local interruptor on an AHB-Lite slave port. It holds the 64-bit machine
// timer mtime, its compare register mtimecmp and the software-interrupt bit
// msip. It drives the timer/software interrupts and the time value straight
// into the privileged unit.
//
// Parameters:
//   XLEN          bus data width, 32 or 64
//   TIMEBASE_DIV  mtime increments once every TIMEBASE_DIV HCLK cycles (>=1)
//
// Ports:
//   HCLK         in   clock
//   HRESETn      in   synchronous active-low reset
//   bus          if   AHB-Lite slave (see clint_ahb_timer_if)
//   MTIME_CLINT  out  current mtime
//   MTimerInt    out  mtime >= mtimecmp (unsigned)
//   MSwInt       out  msip[0]
//
// Register map (byte offsets):
//   0x0000  msip      (bit 0)
//   0x4000  mtimecmp  (XLEN=32: low word 0x4000, high word 0x4004)
//   0xBFF8  mtime     (XLEN=32: low word 0xBFF8, high word 0xBFFC)
// ----------------------------------------------------------------------------
module clint_ahb_timer #(
    parameter int XLEN         = 64,
    parameter int TIMEBASE_DIV = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    clint_ahb_timer_if.slave      bus,
    output logic [63:0]           MTIME_CLINT,
    output logic                  MTimerInt,
    output logic                  MSwInt
);

    localparam int NB = XLEN / 8;
    localparam int AW = $clog2(NB);

    // Decode uses 64-bit slots (HADDR[15:3]); XLEN=32 picks a half with bit 2.
    localparam logic [12:0] SLOT_MSIP  = 13'h0000;
    localparam logic [12:0] SLOT_CMP   = 13'h0800;
    localparam logic [12:0] SLOT_MTIME = 13'h17FF;

    logic [63:0]     mtime_q, mtime_d;
    logic [63:0]     mtimecmp_q, mtimecmp_d;
    logic            msip_q, msip_d;
    logic [15:2]     addr_q, addr_d;
    logic            write_q, write_d;
    logic [NB-1:0]   be_q, be_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            accept;
    logic [NB-1:0]   be_mask;
    int              size_bytes;
    int              lane_off;
    logic [63:0]     rd64;
    logic [XLEN-1:0] rd_word;
    logic [7:0]      be64;
    logic [63:0]     wd64;
    logic            wr_msip, wr_cmp, wr_mtime, mtime_wr;
    logic            tick;
    logic            unused_ok;

    assign unused_ok = &{1'b0, bus.HTRANS[0]};

    assign accept = bus.HSELCLINT & bus.HREADY & bus.HTRANS[1];

    // Byte-enable mask from size and low address bits, little-endian lanes.
    always_comb begin
        be_mask    = '0;
        size_bytes = 1 << bus.HSIZE;
        lane_off   = int'(bus.HADDR[AW-1:0]);
        for (int i = 0; i < NB; i++) begin
            be_mask[i] = (i >= lane_off) && (i < lane_off + size_bytes);
        end
    end

    // Read value of the slot addressed in the current address phase.
    always_comb begin
        rd64 = '0;
        case (bus.HADDR[15:3])
            SLOT_MSIP:  rd64 = {63'b0, msip_q};
            SLOT_CMP:   rd64 = mtimecmp_q;
            SLOT_MTIME: rd64 = mtime_q;
            default:    rd64 = '0;
        endcase
    end

    generate
        if (XLEN == 64) begin : gen_rd64
            assign rd_word = rd64;
        end else begin : gen_rd32
            assign rd_word = bus.HADDR[2] ? rd64[63:32] : rd64[31:0];
        end
    endgenerate

    // Map the captured XLEN-wide lanes onto the 64-bit register view.
    always_comb begin
        be64 = '0;
        wd64 = '0;
        for (int i = 0; i < 8; i++) begin
            be64[i] = be_q[i % NB] && ((NB == 8) || ((i / NB) == int'(addr_q[2])));
            wd64[8*i +: 8] = bus.HWDATA[8*(i % NB) +: 8];
        end
    end

    assign wr_msip  = write_q && (addr_q[15:3] == SLOT_MSIP);
    assign wr_cmp   = write_q && (addr_q[15:3] == SLOT_CMP);
    assign wr_mtime = write_q && (addr_q[15:3] == SLOT_MTIME);
    assign mtime_wr = wr_mtime && (|be64);

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                                input logic [63:0] new_v,
                                                input logic [7:0]  be);
        logic [63:0] r;
        r = old_v;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Prescaler: a software write to mtime restarts the timebase period.
    generate
        if (TIMEBASE_DIV == 1) begin : gen_no_presc
            assign tick = 1'b1;
        end else begin : gen_presc
            localparam int PW = $clog2(TIMEBASE_DIV);
            logic [PW-1:0] presc_q, presc_d;

            assign tick = (presc_q == PW'(TIMEBASE_DIV - 1));

            always_comb begin
                presc_d = presc_q + 1'b1;
                if (mtime_wr || tick) presc_d = '0;
            end

            always_ff @(posedge HCLK) begin
                if (!HRESETn) presc_q <= '0;
                else          presc_q <= presc_d;
            end
        end
    endgenerate

    always_comb begin
        // Write wins over increment; unwritten bytes keep the pre-increment value.
        mtime_d = mtime_q;
        if (mtime_wr)  mtime_d = merge_bytes(mtime_q, wd64, be64);
        else if (tick) mtime_d = mtime_q + 64'd1;

        mtimecmp_d = wr_cmp ? merge_bytes(mtimecmp_q, wd64, be64) : mtimecmp_q;
        msip_d     = (wr_msip && be64[0]) ? wd64[0] : msip_q;

        addr_d  = accept ? bus.HADDR[15:2] : addr_q;
        write_d = accept & bus.HWRITE;
        be_d    = accept ? be_mask : be_q;
        // Read data is sampled from the pre-write registers, so a read right
        // after a write to the same location returns the old value.
        rdata_d = (accept && !bus.HWRITE) ? rd_word : '0;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            be_q       <= '0;
            rdata_q    <= '0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.HREADCLINT  = rdata_q;
    assign bus.HREADYCLINT = 1'b1;
    assign bus.HRESPCLINT  = 1'b0;

    assign MTIME_CLINT = mtime_q;
    assign MTimerInt   = (mtime_q >= mtimecmp_q);
    assign MSwInt      = msip_q;

endmodule

// File: tb/tb_clint_ahb_timer.sv
// ----------------------------------------------------------------------------
// tb_clint_ahb_timer
//
// Three instances share one clock, reset and bus driver:
//   target 0: XLEN=64, TIMEBASE_DIV=1
//   target 1: XLEN=64, TIMEBASE_DIV=4
//   target 2: XLEN=32, TIMEBASE_DIV=1
// Inputs are driven and outputs sampled 1ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_clint_ahb_timer;

    logic hclk = 1'b0;
    logic rstn = 1'b0;
    always #5 hclk = ~hclk;

    int n_cmp = 0;
    int n_bad = 0;

    int          tgt    = 0;
    logic        hsel   = 1'b0;
    logic [15:0] haddr  = '0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize  = 3'd0;
    logic [63:0] hwdata = '0;

    clint_ahb_timer_if #(.XLEN(64)) if64 ();
    clint_ahb_timer_if #(.XLEN(64)) ifd4 ();
    clint_ahb_timer_if #(.XLEN(32)) if32 ();

    assign if64.HSELCLINT = hsel && (tgt == 0);
    assign ifd4.HSELCLINT = hsel && (tgt == 1);
    assign if32.HSELCLINT = hsel && (tgt == 2);
    assign if64.HADDR  = haddr;  assign ifd4.HADDR  = haddr;  assign if32.HADDR  = haddr;
    assign if64.HWRITE = hwrite; assign ifd4.HWRITE = hwrite; assign if32.HWRITE = hwrite;
    assign if64.HTRANS = htrans; assign ifd4.HTRANS = htrans; assign if32.HTRANS = htrans;
    assign if64.HSIZE  = hsize;  assign ifd4.HSIZE  = hsize;  assign if32.HSIZE  = hsize;
    assign if64.HREADY = 1'b1;   assign ifd4.HREADY = 1'b1;   assign if32.HREADY = 1'b1;
    assign if64.HWDATA = hwdata; assign ifd4.HWDATA = hwdata; assign if32.HWDATA = hwdata[31:0];

    logic [63:0] mt64, mtd4, mt32;
    logic        ti64, tid4, ti32;
    logic        si64, sid4, si32;

    clint_ahb_timer #(.XLEN(64), .TIMEBASE_DIV(1)) dut64 (
        .HCLK(hclk), .HRESETn(rstn), .bus(if64),
        .MTIME_CLINT(mt64), .MTimerInt(ti64), .MSwInt(si64)
    );
    clint_ahb_timer #(.XLEN(64), .TIMEBASE_DIV(4)) dutd4 (
        .HCLK(hclk), .HRESETn(rstn), .bus(ifd4),
        .MTIME_CLINT(mtd4), .MTimerInt(tid4), .MSwInt(sid4)
    );
    clint_ahb_timer #(.XLEN(32), .TIMEBASE_DIV(1)) dut32 (
        .HCLK(hclk), .HRESETn(rstn), .bus(if32),
        .MTIME_CLINT(mt32), .MTimerInt(ti32), .MSwInt(si32)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    function automatic logic [63:0] rdata_of(input int t);
        case (t)
            0:       return if64.HREADCLINT;
            1:       return ifd4.HREADCLINT;
            default: return {32'b0, if32.HREADCLINT};
        endcase
    endfunction

    // Address phase, then data phase; returns just after the data-phase edge.
    task automatic ahb_write(input int t, input logic [15:0] a, input logic [2:0] sz,
                             input logic [63:0] d);
        tgt = t; hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = 1'b1; hsize = sz;
        tick();
        bus_idle();
        hwdata = d;
        tick();
        hwdata = '0;
    endtask

    // Returns the data-phase read value sampled just after the accept edge.
    task automatic ahb_read(input int t, input logic [15:0] a, input logic [2:0] sz,
                            output logic [63:0] d);
        tgt = t; hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = 1'b0; hsize = sz;
        tick();
        d = rdata_of(t);
        bus_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic [63:0] prev;
        logic        changed;

        // ---------------- reset and count ----------------
        rstn = 1'b0;
        repeat (3) tick();
        check_eq("rst_mtime64", mt64, 64'd0);
        check_eq("rst_mtimerint", ti64, 1'b0);
        check_eq("rst_mswint", si64, 1'b0);
        check_eq("rst_hread", if64.HREADCLINT, 64'd0);
        check_eq("rst_hready", if64.HREADYCLINT, 1'b1);
        check_eq("rst_hresp", if64.HRESPCLINT, 1'b0);
        check_eq("rst_mtime32", mt32, 64'd0);
        rstn = 1'b1;
        check_eq("count0", mt64, 64'd0);
        tick();
        check_eq("count1", mt64, 64'd1);
        tick();
        check_eq("count2", mt64, 64'd2);
        check_eq("count_d4", mtd4, 64'd0);
        check_eq("count_x32", mt32, 64'd2);
        ahb_read(0, 16'h4000, 3'd3, rd);
        check_eq("rst_mtimecmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        // ---------------- compare ----------------
        ahb_write(0, 16'hBFF8, 3'd3, 64'h10);
        check_eq("mtime_wr", mt64, 64'h10);
        ahb_write(0, 16'h4000, 3'd3, 64'h20);
        check_eq("cmp_mtime", mt64, 64'h12);
        repeat (13) tick();
        check_eq("cmp_pre_mtime", mt64, 64'h1F);
        check_eq("cmp_pre_int", ti64, 1'b0);
        tick();
        check_eq("cmp_hit_mtime", mt64, 64'h20);
        check_eq("cmp_hit_int", ti64, 1'b1);
        ahb_write(0, 16'h4000, 3'd3, 64'h100);
        check_eq("cmp_raise_int", ti64, 1'b0);

        // ---------------- software interrupt ----------------
        ahb_write(0, 16'h0000, 3'd0, 64'h1);
        check_eq("msip_set", si64, 1'b1);
        ahb_read(0, 16'h0000, 3'd3, rd);
        check_eq("msip_read", rd, 64'h1);
        ahb_write(0, 16'h0000, 3'd0, 64'h0);
        check_eq("msip_clr", si64, 1'b0);

        // back-to-back: read in the write's data phase sees the old value
        tgt = 0; hsel = 1'b1; htrans = 2'b10; haddr = 16'h0000; hwrite = 1'b1; hsize = 3'd2;
        tick();
        hwdata = 64'h1; hwrite = 1'b0;
        tick();
        check_eq("rbw_read", if64.HREADCLINT, 64'h0);
        check_eq("rbw_msip", si64, 1'b1);
        bus_idle();
        hwdata = '0;

        // ---------------- sub-word write ----------------
        ahb_write(0, 16'h4003, 3'd0, 64'hAB00_0000);
        ahb_read(0, 16'h4000, 3'd3, rd);
        check_eq("byte_wr_cmp", rd, 64'h0000_0000_AB00_0100);

        // ---------------- unmapped ----------------
        ahb_write(0, 16'h2000, 3'd3, 64'hDEAD_BEEF_DEAD_BEEF);
        ahb_read(0, 16'h2000, 3'd3, rd);
        check_eq("unmapped_read", rd, 64'h0);

        // ---------------- prescaler, write vs increment ----------------
        prev = mtd4;
        changed = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mtd4 != prev) begin
                changed = 1'b1;
                break;
            end
        end
        check_eq("d4_sync", changed, 1'b1);
        // Just after a wrap edge; next wrap is 4 edges out, aligned with the data phase.
        tick();
        tick();
        ahb_write(1, 16'hBFF8, 3'd3, 64'h1000);
        check_eq("d4_wr_wins", mtd4, 64'h1000);
        for (int k = 1; k < 4; k++) begin
            tick();
            check_eq("d4_hold", mtd4, 64'h1000);
        end
        tick();
        check_eq("d4_inc", mtd4, 64'h1001);
        // Write mid-period: prescaler restarts from the write.
        ahb_write(1, 16'hBFF8, 3'd3, 64'h2000);
        repeat (3) tick();
        check_eq("d4_clr_hold", mtd4, 64'h2000);
        tick();
        check_eq("d4_clr_inc", mtd4, 64'h2001);

        // ---------------- XLEN=32 halves ----------------
        ahb_write(2, 16'hBFFC, 3'd2, 64'h5);
        ahb_write(2, 16'hBFF8, 3'd2, 64'hFFFF_FFFF);
        check_eq("x32_mtime_wr", mt32, 64'h5_FFFF_FFFF);
        tick();
        check_eq("x32_carry", mt32, 64'h6_0000_0000);
        ahb_read(2, 16'hBFFC, 3'd2, rd);
        check_eq("x32_read_hi", rd, 64'h6);
        ahb_read(2, 16'hBFF8, 3'd2, rd);
        check_eq("x32_read_lo", rd, 64'h1);
        ahb_read(2, 16'h4004, 3'd2, rd);
        check_eq("x32_cmp_hi", rd, 64'hFFFF_FFFF);

        // ---------------- reset during data phase ----------------
        tgt = 0; hsel = 1'b1; htrans = 2'b10; haddr = 16'h4000; hwrite = 1'b1; hsize = 3'd3;
        tick();
        bus_idle();
        hwdata = 64'h1234;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        hwdata = '0;
        ahb_read(0, 16'h4000, 3'd3, rd);
        check_eq("rst_mid_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("rst_mid_int", ti64, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clint_ahb_timer.md
# clint_ahb_timer

Memory-mapped core-local interruptor (CLINT) on an AHB-Lite slave port. It keeps the 64-bit machine timer `mtime`, the compare register `mtimecmp` and the software-interrupt bit `msip`. It drives `MTimerInt`, `MSwInt` and `MTIME_CLINT` directly into the privileged unit's interrupt and time-CSR inputs. It sits on the uncore bus beside the PLIC, upstream of the privileged unit.

## Interface
- `XLEN`, 64: bus data width, 32 or 64.
- `TIMEBASE_DIV`, 1: `mtime` increments once every `TIMEBASE_DIV` HCLK cycles; ≥1.

Ports:
- `HCLK` in 1: the single clock.
- `HRESETn` in 1: reset, synchronous, active-low.
- `HSELCLINT` in 1: slave select.
- `HADDR` in 16: byte offset within the CLINT region.
- `HWRITE` in 1: 1 = write transfer.
- `HTRANS` in 2: AHB transfer type; `HTRANS[1]` = NONSEQ/SEQ.
- `HSIZE` in 3: transfer size, 0=byte to 3=dword.
- `HREADY` in 1: bus-wide ready; the address phase is accepted only when it is 1.
- `HWDATA` in XLEN: write data, valid in the data phase.
- `HREADCLINT` out XLEN: read data, valid in the data phase.
- `HREADYCLINT` out 1: always 1 (zero wait states).
- `HRESPCLINT` out 1: always 0 (OKAY).
- `MTIME_CLINT` out 64: current `mtime`.
- `MTimerInt` out 1: machine timer interrupt.
- `MSwInt` out 1: machine software interrupt.

## Operation
- Register map, byte offsets:
  - `msip`: 0x0000, bit 0 only; other bits read 0.
  - `mtimecmp`: 0x4000, 64b. For XLEN=32, low word at 0x4000, high word at 0x4004.
  - `mtime`: 0xBFF8, 64b. For XLEN=32, low word at 0xBFF8, high word at 0xBFFC.
  - Any other offset reads 0; writes to it are ignored.
- Address phase:
  - Accept condition is `HSELCLINT & HREADY & HTRANS[1]`.
  - On accept, register `HADDR`, `HWRITE` and a byte-enable mask. The mask comes from `HSIZE` and `HADDR[log2(XLEN/8)-1:0]` (little-endian lane numbering).
  - Register the read data for the decoded location on the same edge, so `HREADCLINT` is valid for the whole following data phase.
- Data phase (a write was captured in the previous cycle):
  - Update the addressed register at the next HCLK edge, from `HWDATA` byte lanes under the captured mask.
  - Sub-word writes modify only the enabled bytes.
- Timebase:
  - A prescaler counts 0..`TIMEBASE_DIV`-1.
  - When it wraps, `mtime` increments by 1, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF wraps to 0).
  - With `TIMEBASE_DIV`=1 the increment happens every cycle and the prescaler is absent.
- Simultaneous events:
  - A write to any byte of `mtime` wins over the increment in that cycle. Unwritten bytes hold their pre-increment value.
  - The same write clears the prescaler to 0.
- Outputs:
  - `MTimerInt` = (`mtime` ≥ `mtimecmp`), unsigned, combinational from the two registers.
  - `MSwInt` = `msip[0]`.
  - `MTIME_CLINT` = `mtime`.
- XLEN=32: hi/lo accesses are independent. There is no snapshot; software handles carry between the halves.
- Back-to-back transfers: a new address phase may be accepted in the same cycle as the previous data phase. A read of a register written in the immediately preceding data phase returns the pre-write value; this is read-before-write, and software must tolerate it.

## Timing
- Reset (`HRESETn`=0 at a rising edge) gives:
  - `mtime`=0, `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, `msip`=0, prescaler=0.
  - Captured address, write flag and mask cleared.
  - `HREADCLINT`=0, `MTimerInt`=0, `MSwInt`=0, `MTIME_CLINT`=0.
- Reset asserted mid-transfer: the pending data-phase write is dropped.
- Read latency: 1 cycle. Address accepted at edge N; `HREADCLINT` is valid from edge N until edge N+1.
- Write latency: register updated at edge N+1, data phase. `MTimerInt` and `MSwInt` reflect the new value immediately after that edge.
- `mtime` update:
  - Changes only at edges where the prescaler wraps or a write occurs.
  - `MTimerInt` asserts in the same cycle `mtime` first equals `mtimecmp`.
  - It stays high until `mtimecmp` is raised above `mtime` or `mtime` is written below `mtimecmp`.
- `HREADYCLINT`=1 and `HRESPCLINT`=0 in every cycle, including reset.

## Test plan
- **Reset and count:**
  - Stimulus: release reset with `TIMEBASE_DIV`=1.
  - Required: `MTIME_CLINT` reads 0, 1, 2… on successive cycles; `MTimerInt`=0; `MSwInt`=0; an AHB read of 0x4000 returns 0xFFFF_FFFF_FFFF_FFFF.
- **Compare:**
  - Stimulus: write `mtimecmp`=0x20.
  - Required: `MTimerInt` rises in exactly the cycle `MTIME_CLINT`=0x20.
  - Stimulus: then write `mtimecmp`=0x100.
  - Required: `MTimerInt` falls the edge after the data phase.
- **Software interrupt:**
  - Stimulus: write 1 to 0x0000.
  - Required: `MSwInt`=1 after the data-phase edge; a read of 0x0000 returns 1.
  - Stimulus: write 0.
  - Required: `MSwInt`=0.
- **Write vs increment, prescaler:**
  - Stimulus: `TIMEBASE_DIV`=4; write `mtime`=0x1000 in a cycle where the prescaler would wrap.
  - Required: `mtime`=0x1000, holding for 4 cycles, then 0x1001.
- **Sub-word and XLEN=32:**
  - Stimulus: byte write 0xAB to 0x4003.
  - Required: only `mtimecmp[31:24]` changes.
  - Stimulus: with XLEN=32, write 0xFFFF_FFFF to 0xBFF8, then let `mtime` increment.
  - Required: the high word at 0xBFFC increments by 1 and the low word wraps to 0.
- **Unmapped and reset mid-transfer:**
  - Stimulus: read 0x2000.
  - Required: returns 0.
  - Stimulus: assert reset during the data phase of an `mtimecmp` write.
  - Required: `mtimecmp` = all ones after reset.
